count_display_driver: RTL and testbench
=======================================

// Module: count_display_driver
// PURPOSE
//  Reads the 16-bit count produced by the UI button counter and shows it on a
//  4-digit multiplexed 7-segment display: decimal (with leading-zero blanking)
//  or hex. Sequential double-dabble binary->BCD converter plus a refresh scanner.
//  Sits between the counter output and board display pins.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles each digit stays enabled (>=2)
//  LZ_BLANK     1      1 = blank leading zeros (digit 0 never blanked)
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  rst       in   1   synchronous reset, active-high
//  value     in   16  unsigned count to display
//  hex_mode  in   1   1 = hex display, 0 = decimal
//  an        out  4   digit enables, active-low, an[0] = rightmost digit
//  seg       out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp        out  1   decimal point, active-low, always 1 (off)
//  busy      out  1   high while a conversion is in flight
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: an=4'b1111, seg=7'b1111111, dp=1, busy=0, FSM=IDLE, refresh cnt=0,
//   digit idx=0, display reg = value 0, ovf=0, pending flag set. Reset
//   mid-conversion aborts it; partial results are discarded.
//  FSM IDLE/SHIFT/COMMIT:
//   IDLE: capture if pending, or value!=last_value, or hex_mode!=last_mode.
//    Capture latches value and mode, clears pending, sets ovf=(dec && value>9999).
//    Decimal -> SHIFT; hex -> COMMIT.
//   SHIFT: 16 cycles of double-dabble (add 3 to any BCD nibble >=5, then shift
//    left 1). 20-bit BCD scratch; only the low 4 digits are kept.
//   COMMIT: 1 cycle, loads display reg (4 nibbles + ovf + mode), -> IDLE.
//  Latency (capture edge to display reg update): decimal 17 clk, hex 1 clk.
//  busy=1 in SHIFT and COMMIT. Input changes during busy are ignored; they are
//   caught by the compare in the next IDLE cycle (last_value = captured value).
//  Display reg changes only at COMMIT, so digits never show a partial result.
//  Refresh: counter 0..REFRESH_DIV-1; on wrap, digit idx = (idx+1) mod 4.
//  an/seg are registered: they reflect digit idx and display reg 1 clk later.
//   Exactly one an bit is low outside reset.
//  Decode: 0-9,A,b,C,d,E,F standard (0=7'b1000000, 1=7'b1111001, ...).
//   Blank = 7'b1111111. ovf -> every digit '-' = 7'b0111111.
//  Blanking (LZ_BLANK=1, ovf=0, both modes): digit k>0 is blanked if it and all
//   higher digits are 0.
// TESTING (REFRESH_DIV=4)
//  1. Reset, value=0, dec -> after 18 clk busy=0; an[0] low: seg=7'b1000000;
//     an[1..3] low: seg=7'b1111111.
//  2. value=1234, dec -> busy 17 clk; scan gives digits 4,3,2,1 on an[0..3]
//     (seg 7'b0011001, 0110000, 0100100, 1111001).
//  3. value=10000, dec -> ovf; all four digits show 7'b0111111.
//  4. hex_mode=1, value=16'hBEEF -> display updates 1 clk after capture;
//     an[3..0] show b,E,E,F.
//  5. value=5, then value=42 on the 5th SHIFT cycle -> display shows 5, then a
//     second conversion starts the cycle after COMMIT; display shows 42.
//  6. rst pulsed mid-SHIFT -> next clk busy=0, an=4'b1111; display "0", then
//     the held value is reconverted and shown 17 clk after capture.

Source files
------------

// File: rtl/count_display_driver.sv
// count_display_driver
//
// Shows a 16-bit unsigned count on a 4-digit multiplexed 7-segment display.
// The display can be decimal, with leading zeros blanked, or hex. A
// sequential double-dabble converter turns the binary count into BCD. The
// display register is loaded only when a conversion finishes, so the digits
// never show a partial result. A refresh scanner enables one digit at a time.
//
// Ports
//   clk       in   1   system clock, all logic on posedge
//   rst       in   1   synchronous reset, active-high
//   value     in   16  unsigned count to display
//   hex_mode  in   1   1 = hex display, 0 = decimal
//   an        out  4   digit enables, active-low, an[0] = rightmost digit
//   seg       out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1   decimal point, active-low, always off
//   busy      out  1   high while a conversion is in flight
//
// Conversion FSM
//   state  | meaning
//   IDLE   | watch for a new value/mode (or the post-reset pending flag)
//   SHIFT  | 16 double-dabble steps: add 3 to BCD nibbles >= 5, then shift
//   COMMIT | load the display register with the finished digits
module count_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int             CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [15:0]   last_value_q, last_value_d;
  logic          last_mode_q, last_mode_d;
  logic [15:0]   bin_q, bin_d;
  logic [19:0]   bcd_q, bcd_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          mode_cap_q, mode_cap_d;
  logic          ovf_cap_q, ovf_cap_d;
  logic [15:0]   disp_digits_q, disp_digits_d;
  logic          disp_ovf_q, disp_ovf_d;
  logic          disp_mode_q, disp_mode_d;
  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          busy_q, busy_d;

  logic [19:0]   bcd_adj;
  logic [3:0]    nib;
  logic [3:0]    lead_blank;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    last_value_d  = last_value_q;
    last_mode_d   = last_mode_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    bit_cnt_d     = bit_cnt_q;
    mode_cap_d    = mode_cap_q;
    ovf_cap_d     = ovf_cap_q;
    disp_digits_d = disp_digits_q;
    disp_ovf_d    = disp_ovf_q;
    disp_mode_d   = disp_mode_q;
    bcd_adj       = dd_adjust(bcd_q);

    case (state_q)
      IDLE: begin
        // Inputs that moved while busy are picked up here, because the
        // comparison is against the value actually captured.
        if (pending_q || (value != last_value_q) || (hex_mode != last_mode_q)) begin
          pending_d    = 1'b0;
          last_value_d = value;
          last_mode_d  = hex_mode;
          bin_d        = value;
          bcd_d        = '0;
          bit_cnt_d    = 4'd15;
          mode_cap_d   = hex_mode;
          ovf_cap_d    = !hex_mode && (value > 16'd9999);
          state_d      = hex_mode ? COMMIT : SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        if (bit_cnt_q == 4'd0) begin
          state_d = COMMIT;
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end
      COMMIT: begin
        // Hex mode never shifts, so bin_q still holds the captured value.
        disp_digits_d = mode_cap_q ? bin_q : bcd_q[15:0];
        disp_ovf_d    = ovf_cap_q;
        disp_mode_d   = mode_cap_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    digit_idx_d   = digit_idx_q;
    if (refresh_cnt_q == REF_LAST) begin
      refresh_cnt_d = '0;
      digit_idx_d   = digit_idx_q + 2'd1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + CW'(1);
    end
  end

  // A digit above position 0 is blank when it and every digit above it are 0.
  always_comb begin
    lead_blank[3] = (disp_digits_q[15:12] == 4'd0);
    lead_blank[2] = lead_blank[3] && (disp_digits_q[11:8] == 4'd0);
    lead_blank[1] = lead_blank[2] && (disp_digits_q[7:4] == 4'd0);
    lead_blank[0] = 1'b0;
  end

  always_comb begin
    nib  = disp_digits_q[{digit_idx_q, 2'b00} +: 4];
    an_d = ~(4'b0001 << digit_idx_q);
    if (disp_ovf_q) begin
      seg_d = SEG_DASH;
    end else if (LZ_BLANK && lead_blank[digit_idx_q]) begin
      seg_d = SEG_BLANK;
    end else if (!disp_mode_q && (nib > 4'd9)) begin
      // Cannot come out of the converter; blank rather than show a hex letter.
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg7(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= 1'b1;
      last_value_q  <= '0;
      last_mode_q   <= 1'b0;
      bin_q         <= '0;
      bcd_q         <= '0;
      bit_cnt_q     <= '0;
      mode_cap_q    <= 1'b0;
      ovf_cap_q     <= 1'b0;
      disp_digits_q <= '0;
      disp_ovf_q    <= 1'b0;
      disp_mode_q   <= 1'b0;
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_BLANK;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      last_value_q  <= last_value_d;
      last_mode_q   <= last_mode_d;
      bin_q         <= bin_d;
      bcd_q         <= bcd_d;
      bit_cnt_q     <= bit_cnt_d;
      mode_cap_q    <= mode_cap_d;
      ovf_cap_q     <= ovf_cap_d;
      disp_digits_q <= disp_digits_d;
      disp_ovf_q    <= disp_ovf_d;
      disp_mode_q   <= disp_mode_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      busy_q        <= busy_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = busy_q;

endmodule

// File: tb/tb_count_display_driver.sv
module tb_count_display_driver;

  localparam int RDIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        hex_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  always #5 clk = ~clk;

  count_display_driver #(.REFRESH_DIV(RDIV), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .hex_mode(hex_mode),
    .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  // Expected result of one busy episode; segs = {an3, an2, an1, an0}.
  typedef struct packed {
    logic [7:0]      len;
    logic            abort;
    logic [3:0][6:0] segs;
  } exp_t;

  typedef struct packed {
    logic [7:0] len;
    logic       abort;
    logic [3:0] an;
    logic [6:0] seg;
  } fall_t;

  exp_t  exp_q[$];
  fall_t fall_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    issued   = 0;
  int    done_cnt = 0;
  int    busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Records the end of every busy episode (conversion finished or reset).
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_run++;
    end else begin
      if (busy_run > 0) begin
        fall_q.push_back('{len: 8'(busy_run), abort: rst, an: an, seg: seg});
      end
      busy_run = 0;
    end
  end

  task automatic scan_and_check(input exp_t e);
    logic [3:0][6:0] got;
    logic [3:0]      seen;
    logic            onehot_ok;
    logic            dp_ok;
    got       = 'x;
    seen      = '0;
    onehot_ok = 1'b1;
    dp_ok     = 1'b1;
    @(negedge clk);
    repeat (4 * RDIV) begin
      @(negedge clk);
      case (an)
        4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
        4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
        4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
        4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
        default: onehot_ok = 1'b0;
      endcase
      if (dp !== 1'b1) dp_ok = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seg_an%0d", k), {25'd0, got[k]}, {25'd0, e.segs[k]});
    end
    check("an_one_low", {31'd0, onehot_ok}, 32'd1);
    check("digits_seen", {28'd0, seen}, 32'hF);
    check("dp_off", {31'd0, dp_ok}, 32'd1);
  endtask

  // Monitor: pairs each observed busy episode with the oldest expectation.
  initial begin
    fall_t f;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (fall_q.size() != 0) begin
        f = fall_q.pop_front();
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_episode: got busy length %0d with no expectation queued", f.len);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", {24'd0, f.len}, {24'd0, e.len});
          check("aborted", {31'd0, f.abort}, {31'd0, e.abort});
          if (e.abort) begin
            check("an_in_reset", {28'd0, f.an}, 32'hF);
            check("seg_in_reset", {25'd0, f.seg}, 32'h7F);
          end else begin
            scan_and_check(e);
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic expect_item(input logic [7:0] len, input logic abort,
                             input logic [3:0][6:0] segs);
    exp_q.push_back('{len: len, abort: abort, segs: segs});
    issued++;
  endtask

  task automatic apply(input logic [15:0] v, input logic m);
    @(posedge clk);
    #1;
    value    = v;
    hex_mode = m;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cnt != issued && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt != issued) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: got %0d results, expected %0d", name, done_cnt, issued);
      done_cnt = issued;
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    value    = 16'd0;
    hex_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_seg", {25'd0, seg}, 32'h7F);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dp", {31'd0, dp}, 32'd1);

    // Pending flag forces a conversion of 0 right after reset.
    expect_item(8'd17, 1'b0, {BL, BL, BL, S0});
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done("reset_zero");

    expect_item(8'd17, 1'b0, {S1, S2, S3, S4});
    apply(16'd1234, 1'b0);
    wait_done("dec_1234");

    expect_item(8'd17, 1'b0, {DS, DS, DS, DS});
    apply(16'd10000, 1'b0);
    wait_done("dec_ovf");

    expect_item(8'd17, 1'b0, {S9, S9, S9, S9});
    apply(16'd9999, 1'b0);
    wait_done("dec_9999");

    expect_item(8'd1, 1'b0, {SB, SE, SE, SF});
    apply(16'hBEEF, 1'b1);
    wait_done("hex_beef");

    expect_item(8'd1, 1'b0, {BL, SA, S0, S5});
    apply(16'h0A05, 1'b1);
    wait_done("hex_0a05");

    expect_item(8'd1, 1'b0, {BL, BL, S1, S0});
    apply(16'h0010, 1'b1);
    wait_done("hex_0010");

    // Mode change alone triggers a reconversion: 0x0010 = 16 decimal.
    expect_item(8'd17, 1'b0, {BL, BL, S1, S6});
    apply(16'h0010, 1'b0);
    wait_done("mode_switch");

    // Value changes mid-SHIFT: 5 finishes first, then 42 is converted.
    expect_item(8'd17, 1'b0, {BL, BL, BL, S5});
    expect_item(8'd17, 1'b0, {BL, BL, S4, S2});
    apply(16'd5, 1'b0);
    repeat (5) @(posedge clk);
    #1 value = 16'd42;
    wait_done("change_while_busy");

    // Reset after 6 busy cycles aborts; the held value is then reconverted.
    expect_item(8'd6, 1'b1, {BL, BL, BL, BL});
    expect_item(8'd17, 1'b0, {BL, S7, S7, S7});
    apply(16'd777, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_done("reset_mid_shift");

    check("exp_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
